// File: rtl/compound_receiver_pkg.sv
// Shared types for the compound receiver: producer message layout, accumulator
// arithmetic and the receiver's section enum.
package scam_model_types;

  // y=1 accumulates x (sign-extended) modulo 2^32; y=0 loads x reinterpreted as unsigned.
  function automatic logic [31:0] scam_accumulate(input logic [31:0] acc,
                                                  input logic signed [31:0] x,
                                                  input logic y);
    logic [31:0] x_bits;
    x_bits = unsigned'(x);
    return y ? (acc + x_bits) : x_bits;
  endfunction

endpackage

package testbasic22_types;

  typedef struct packed {
    logic signed [31:0] x;
    logic               y;
  } test_compound;

endpackage

package compound_receiver_types;

  typedef enum logic [1:0] {
    section_idle = 2'd0,
    section_proc = 2'd1,
    section_send = 2'd2
  } Sections;

endpackage

// File: rtl/compound_receiver.sv
// Receives test_compound messages, folds them into a 32-bit accumulator and
// offers each result downstream with a notify/sync handshake.
module compound_receiver
  import scam_model_types::*;
  import testbasic22_types::*;
  import compound_receiver_types::*;
#(
  parameter logic [31:0] ACC_INIT = 32'd30
) (
  input  logic         clk,
  input  logic         rst,
  input  test_compound b_in,
  input  logic         b_in_sync,
  output logic         b_in_notify,
  output logic [31:0]  m_out,
  output logic         m_out_notify,
  input  logic         m_out_sync,
  output logic [7:0]   rx_count
);

  Sections      state_reg;
  test_compound msg_reg;
  logic [31:0]  acc_reg;
  logic [31:0]  acc_next;

  always_comb begin
    acc_next = scam_accumulate(acc_reg, msg_reg.x, msg_reg.y);
  end

  // Input and output phases never overlap: b_in_notify is only high in section_idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= section_idle;
      msg_reg      <= '0;
      acc_reg      <= ACC_INIT;
      m_out        <= '0;
      m_out_notify <= 1'b0;
      b_in_notify  <= 1'b1;
      rx_count     <= '0;
    end else begin
      case (state_reg)
        section_idle: begin
          if (b_in_notify && b_in_sync) begin
            msg_reg     <= b_in;
            b_in_notify <= 1'b0;
            rx_count    <= rx_count + 8'd1;
            state_reg   <= section_proc;
          end
        end
        section_proc: begin
          acc_reg      <= acc_next;
          m_out        <= acc_next;
          m_out_notify <= 1'b1;
          state_reg    <= section_send;
        end
        section_send: begin
          if (m_out_sync) begin
            m_out_notify <= 1'b0;
            b_in_notify  <= 1'b1;
            state_reg    <= section_idle;
          end
        end
        default: begin
          state_reg <= section_idle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_compound_receiver.sv
// Directed self-checking bench for compound_receiver; inputs driven and outputs
// sampled on the falling edge.
module tb_compound_receiver;
  import testbasic22_types::*;

  logic         clk;
  logic         rst;
  test_compound b_in;
  logic         b_in_sync;
  logic         b_in_notify;
  logic [31:0]  m_out;
  logic         m_out_notify;
  logic         m_out_sync;
  logic [7:0]   rx_count;

  int tests_run;
  int tests_failed;
  int notify_seen;

  compound_receiver #(.ACC_INIT(32'd30)) dut (
    .clk          (clk),
    .rst          (rst),
    .b_in         (b_in),
    .b_in_sync    (b_in_sync),
    .b_in_notify  (b_in_notify),
    .m_out        (m_out),
    .m_out_notify (m_out_notify),
    .m_out_sync   (m_out_sync),
    .rx_count     (rx_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  // Called at a falling edge in idle; result is registered on the second rising edge.
  task automatic xfer(input logic signed [31:0] x, input logic y,
                      input logic [31:0] exp, input string tag);
    b_in.x    = x;
    b_in.y    = y;
    b_in_sync = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_in_sync = 1'b0;
    check_val({tag, "_proc_notify"}, {31'd0, b_in_notify | m_out_notify}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_val({tag, "_m_out"}, m_out, exp);
    check_val({tag, "_m_out_notify"}, {31'd0, m_out_notify}, 32'd1);
    if (m_out_sync) begin
      @(posedge clk);
      @(negedge clk);
      check_val({tag, "_done"}, {30'd0, m_out_notify, b_in_notify}, 32'd1);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    notify_seen  = 0;
    rst          = 1'b0;
    b_in         = '0;
    b_in_sync    = 1'b0;
    m_out_sync   = 1'b0;

    repeat (2) @(negedge clk);
    check_val("rst_b_in_notify", {31'd0, b_in_notify}, 32'd1);
    check_val("rst_m_out", m_out, 32'd0);
    check_val("rst_m_out_notify", {31'd0, m_out_notify}, 32'd0);
    check_val("rst_rx_count", {24'd0, rx_count}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check_val("idle_b_in_notify", {31'd0, b_in_notify}, 32'd1);

    // Accumulate onto ACC_INIT, then a plain load of a negative value.
    m_out_sync = 1'b1;
    xfer(32'sd5, 1'b1, 32'd35, "acc5");
    xfer(-32'sd3, 1'b0, 32'hFFFF_FFFD, "load_m3");
    check_val("rx_count_2", {24'd0, rx_count}, 32'd2);

    // Backpressure: 0xFFFFFFFD + 7 wraps to 4; a b_in_sync pulse mid-stall is ignored.
    m_out_sync = 1'b0;
    xfer(32'sd7, 1'b1, 32'd4, "bp");
    for (int i = 0; i < 10; i++) begin
      b_in_sync = (i == 4);
      b_in.x    = 32'sd100;
      b_in.y    = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_val($sformatf("bp_hold%0d", i),
                {m_out[29:0], m_out_notify, b_in_notify}, {30'd4, 1'b1, 1'b0});
    end
    b_in_sync = 1'b0;
    check_val("bp_rx_count", {24'd0, rx_count}, 32'd3);
    m_out_sync = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("bp_release", {30'd0, m_out_notify, b_in_notify}, 32'd1);
    check_val("bp_m_out_kept", m_out, 32'd4);
    @(posedge clk);
    @(negedge clk);
    check_val("idle_sync_ignored", {m_out[29:0], m_out_notify, b_in_notify}, {30'd4, 1'b0, 1'b1});

    // 32-bit wrap of the accumulate path.
    xfer(-32'sd1, 1'b0, 32'hFFFF_FFFF, "load_m1");
    xfer(32'sd2, 1'b1, 32'd1, "wrap_add2");
    check_val("rx_count_5", {24'd0, rx_count}, 32'd5);

    // 251 back-to-back messages of +1 at one per 3 cycles bring rx_count to 256 -> 0.
    b_in.x    = 32'sd1;
    b_in.y    = 1'b1;
    b_in_sync = 1'b1;
    for (int i = 0; i < 753; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (m_out_notify) notify_seen++;
    end
    b_in_sync = 1'b0;
    check_val("b2b_outputs", notify_seen, 32'd251);
    check_val("b2b_rx_count_wrap", {24'd0, rx_count}, 32'd0);
    check_val("b2b_m_out", m_out, 32'd252);
    check_val("b2b_idle", {30'd0, m_out_notify, b_in_notify}, 32'd1);

    // Reset while offering a result aborts it; the next message sees ACC_INIT.
    m_out_sync = 1'b0;
    xfer(32'sd9, 1'b1, 32'd261, "pre_rst");
    #2 rst = 1'b0;
    #1;
    check_val("rst_send_notify", {31'd0, m_out_notify}, 32'd0);
    check_val("rst_send_state", {m_out[22:0], b_in_notify, rx_count}, {23'd0, 1'b1, 8'd0});
    @(negedge clk);
    rst        = 1'b1;
    m_out_sync = 1'b1;
    xfer(32'sd1, 1'b1, 32'd31, "post_rst");
    check_val("post_rst_rx_count", {24'd0, rx_count}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/compound_receiver.md
COMPOUND_RECEIVER -- requirements
Module: compound_receiver

Interface
REQ-001 Parameter: ACC_INIT, 30, accumulator reset value (32-bit).
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low.
REQ-004 b_in  input  test_compound  message from the producer: x is 32-bit signed, y is bool.
REQ-005 b_in_sync  input  1  producer has valid data on b_in.
REQ-006 b_in_notify  output  1  receiver ready to accept b_in.
REQ-007 m_out  output  32  accumulated result, unsigned bit vector.
REQ-008 m_out_notify  output  1  m_out is valid and offered downstream.
REQ-009 m_out_sync  input  1  downstream accepts m_out.
REQ-010 rx_count  output  8  number of messages accepted, wrapping.

Function
REQ-011 The block SHALL implement a three-state machine of type Sections with states section_idle, section_proc and section_send.
REQ-012 Input handshake: a transfer SHALL occur on a rising edge where b_in_notify=1 and b_in_sync=1, in section_idle only.
REQ-013 On an input transfer, the block SHALL latch b_in, drive b_in_notify=0 from the next cycle, increment rx_count modulo 256, and go to section_proc.
REQ-014 section_proc SHALL last exactly one cycle.
REQ-015 In section_proc, if y=1 the block SHALL compute acc <= acc + x, with x sign-extended and the sum wrapping modulo 2^32.
REQ-016 In section_proc, if y=0 the block SHALL compute acc <= x, reinterpreted as 32-bit unsigned.
REQ-017 In section_proc, the block SHALL load m_out with the new acc value, set m_out_notify=1 and go to section_send.
REQ-018 m_out and m_out_notify SHALL be registered; m_out SHALL appear 2 cycles after the input transfer edge.
REQ-019 In section_send, m_out and m_out_notify SHALL hold stable until a rising edge where m_out_sync=1.
REQ-020 On that edge, m_out_notify SHALL go to 0 and b_in_notify to 1, and the state SHALL return to section_idle.
REQ-021 m_out SHALL retain its last value after the output handshake.
REQ-022 b_in_sync while not in section_idle SHALL be ignored: no latch, no count change.
REQ-023 m_out_sync while m_out_notify=0 SHALL be ignored.
REQ-024 Minimum throughput SHALL be one message per 3 cycles when m_out_sync is tied to 1.
REQ-025 A new input SHALL be accepted no earlier than the cycle after the output handshake; there is no input/output overlap.
REQ-026 rx_count SHALL wrap from 255 to 0 with no flag.

Reset
REQ-027 When rst=0, asynchronously and regardless of state: state=section_idle, acc=ACC_INIT, m_out=0, m_out_notify=0, b_in_notify=1, rx_count=0, latched message=0.
REQ-028 Reset asserted mid-transfer (section_proc or section_send) SHALL abort that message with no output handshake; the first message after release SHALL see acc=ACC_INIT.
REQ-029 On the first rising edge after rst returns to 1, the block SHALL be able to accept input if b_in_sync=1.

Structure
REQ-030 The Sections enum SHALL reside in shared package compound_receiver_types.
REQ-031 test_compound SHALL be reused from testbasic22_types and SHALL NOT be redefined.
REQ-032 The block SHALL import scam_model_types.
REQ-033 No sub-module is required; state machine and datapath SHALL be a single module.

Verification
REQ-034 Reset then idle: b_in_notify=1, m_out=0, m_out_notify=0, rx_count=0.
REQ-035 Accumulate then load: send {x=5,y=1} with m_out_sync=1 -> m_out=35, 2 cycles after transfer; then send {x=-3,y=0} -> m_out=0xFFFFFFFD.
REQ-036 Backpressure: m_out_sync=0 for 10 cycles -> m_out/notify stable, b_in_notify=0, a b_in_sync pulse is ignored with rx_count unchanged; release -> return to idle.
REQ-037 Wrap: acc=0xFFFFFFFF (via {x=-1,y=0}), then {x=2,y=1} -> m_out=1.
REQ-038 Counter wrap: 256 transfers -> rx_count=0; back-to-back with m_out_sync=1 -> one output every 3 cycles.
REQ-039 Reset in section_send -> m_out_notify drops immediately; next {x=1,y=1} -> m_out=31.
